// File: rtl/data_packing_pkg.sv
// Shared helpers for the chunk/fragment packing blocks: single-wrap pointer
// arithmetic for non-power-of-two rings and request-size clipping.
package data_packing_pkg;

  // One compare-and-subtract is enough as long as ptr < cap and inc <= cap.
  function automatic int unsigned wrap_add(input int unsigned ptr,
                                           input int unsigned inc,
                                           input int unsigned cap);
    int unsigned sum;
    sum = ptr + inc;
    if (sum >= cap) sum = sum - cap;
    return sum;
  endfunction

  function automatic int unsigned clip_size(input int unsigned size,
                                            input int unsigned max);
    return (size > max) ? max : size;
  endfunction

endpackage

// File: rtl/chunk_to_fragment.sv
// Unpacks fixed-size input chunks into downstream-sized fragments through a
// ring buffer holding two chunks' worth of elements.
module chunk_to_fragment
  import data_packing_pkg::*;
#(
  parameter int  S_IN      = 8,
  parameter int  S_MAX_OUT = 4,
  parameter type T         = logic,
  localparam int SZ_W      = $clog2(S_MAX_OUT + 1)
) (
  input  logic            i_clk,
  input  logic            i_async_rst_n,
  input  logic            i_chunk_valid,
  input  T                i_chunk [S_IN],
  output logic            o_us_ready,
  input  logic [SZ_W-1:0] i_frag_size,
  input  logic            i_ds_ready,
  output logic            o_frag_valid,
  output T                o_frag [S_MAX_OUT],
  output logic [SZ_W-1:0] o_frag_size
);

  localparam int CAP   = 2 * S_IN;
  localparam int PTR_W = $clog2(CAP);
  localparam int CNT_W = $clog2(CAP + 1);

  if (S_MAX_OUT < 1 || S_MAX_OUT > S_IN) begin : g_param_check
    $error("chunk_to_fragment: S_MAX_OUT must be in 1..S_IN");
  end

  T                 r_buf [CAP];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_cnt;

  logic [SZ_W-1:0]  req;
  logic [PTR_W-1:0] wr_ptr;
  logic             us_ready_int;
  logic             frag_valid_int;
  logic             push;
  logic             pop;

  always_comb begin
    req            = SZ_W'(clip_size(32'(i_frag_size), 32'(S_MAX_OUT)));
    us_ready_int   = (32'(r_cnt) <= 32'(CAP - S_IN));
    frag_valid_int = (req != '0) && (32'(r_cnt) >= 32'(req));
    push           = i_chunk_valid && us_ready_int;
    pop            = frag_valid_int && i_ds_ready;
    wr_ptr         = PTR_W'(wrap_add(32'(r_rd_ptr), 32'(r_cnt), 32'(CAP)));
  end

  // Outputs are forced quiet while reset is held, independent of the clock.
  always_comb begin
    o_us_ready   = i_async_rst_n && us_ready_int;
    o_frag_valid = i_async_rst_n && frag_valid_int;
    o_frag_size  = i_async_rst_n ? req : '0;
    for (int i = 0; i < S_MAX_OUT; i++) begin
      o_frag[i] = '0;
      if (i_async_rst_n && (32'(i) < 32'(req)))
        o_frag[i] = r_buf[PTR_W'(wrap_add(32'(r_rd_ptr), 32'(i), 32'(CAP)))];
    end
  end

  // Push and pop may coincide; the write region never overlaps live data
  // because a push is only accepted with at most CAP - S_IN elements stored.
  always_ff @(posedge i_clk or negedge i_async_rst_n) begin
    if (!i_async_rst_n) begin
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      for (int i = 0; i < CAP; i++) r_buf[i] <= '0;
    end else begin
      if (push) begin
        for (int i = 0; i < S_IN; i++)
          r_buf[PTR_W'(wrap_add(32'(wr_ptr), 32'(i), 32'(CAP)))] <= i_chunk[i];
      end
      if (pop)
        r_rd_ptr <= PTR_W'(wrap_add(32'(r_rd_ptr), 32'(req), 32'(CAP)));
      r_cnt <= r_cnt + (push ? CNT_W'(S_IN) : '0) - (pop ? CNT_W'(req) : '0);
    end
  end

endmodule

// File: tb/tb_chunk_to_fragment.sv
// Self-checking bench for chunk_to_fragment: an element-queue model checked
// every cycle, plus directed vectors with hand-computed fragments.
module tb_chunk_to_fragment;

  logic       i_clk = 1'b0;
  logic       i_async_rst_n;
  logic       i_chunk_valid;
  logic [7:0] i_chunk [8];
  logic       o_us_ready;
  logic [2:0] i_frag_size;
  logic       i_ds_ready;
  logic       o_frag_valid;
  logic [7:0] o_frag [4];
  logic [2:0] o_frag_size;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] model_q [$];

  chunk_to_fragment #(
    .S_IN(8),
    .S_MAX_OUT(4),
    .T(logic [7:0])
  ) dut (
    .i_clk(i_clk),
    .i_async_rst_n(i_async_rst_n),
    .i_chunk_valid(i_chunk_valid),
    .i_chunk(i_chunk),
    .o_us_ready(o_us_ready),
    .i_frag_size(i_frag_size),
    .i_ds_ready(i_ds_ready),
    .o_frag_valid(o_frag_valid),
    .o_frag(o_frag),
    .o_frag_size(o_frag_size)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int clipped(input logic [2:0] fs);
    return (int'(fs) > 4) ? 4 : int'(fs);
  endfunction

  // Element-level model: a FIFO of bytes, chunks appended, fragments removed.
  always @(posedge i_clk or negedge i_async_rst_n) begin : model_update
    int  r;
    bit  do_push;
    bit  do_pop;
    if (!i_async_rst_n) begin
      model_q.delete();
    end else begin
      r       = clipped(i_frag_size);
      do_push = i_chunk_valid && (model_q.size() <= 8);
      do_pop  = (r != 0) && (model_q.size() >= r) && i_ds_ready;
      if (do_pop) repeat (r) void'(model_q.pop_front());
      if (do_push) for (int i = 0; i < 8; i++) model_q.push_back(i_chunk[i]);
    end
  end

  always @(negedge i_clk) begin : compare
    int         r;
    logic       exp_valid;
    logic [7:0] exp_elem;
    #2;
    r = clipped(i_frag_size);
    if (!i_async_rst_n) begin
      check("cmp_rst_ready", 32'(o_us_ready), 32'd0);
      check("cmp_rst_valid", 32'(o_frag_valid), 32'd0);
      check("cmp_rst_size", 32'(o_frag_size), 32'd0);
    end else begin
      exp_valid = (r != 0) && (model_q.size() >= r);
      check("cmp_ready", 32'(o_us_ready), 32'(model_q.size() <= 8));
      check("cmp_valid", 32'(o_frag_valid), 32'(exp_valid));
      check("cmp_size", 32'(o_frag_size), 32'(r));
      if (exp_valid) begin
        for (int i = 0; i < 4; i++) begin
          exp_elem = (i < r) ? model_q[i] : 8'h00;
          check($sformatf("cmp_frag[%0d]", i), 32'(o_frag[i]), 32'(exp_elem));
        end
      end
    end
  end

  task automatic apply_stimulus(input logic cv, input logic [7:0] base,
                                input logic [2:0] fs, input logic dr);
    @(negedge i_clk);
    i_chunk_valid = cv;
    for (int i = 0; i < 8; i++) i_chunk[i] = base + 8'(i);
    i_frag_size = fs;
    i_ds_ready  = dr;
    #3;
  endtask

  task automatic check_output(input string name, input logic exp_valid,
                              input int exp_size, input logic [31:0] exp_frag);
    check({name, "_valid"}, 32'(o_frag_valid), 32'(exp_valid));
    check({name, "_size"}, 32'(o_frag_size), 32'(exp_size));
    if (exp_valid)
      check({name, "_frag"}, {o_frag[0], o_frag[1], o_frag[2], o_frag[3]}, exp_frag);
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_chunk_valid = 1'b0;
    i_frag_size   = 3'd0;
    i_ds_ready    = 1'b0;
    i_async_rst_n = 1'b0;
    @(negedge i_clk);
    i_async_rst_n = 1'b1;
  endtask

  initial begin
    i_async_rst_n = 1'b0;
    i_chunk_valid = 1'b0;
    i_frag_size   = 3'd3;
    i_ds_ready    = 1'b0;
    for (int i = 0; i < 8; i++) i_chunk[i] = 8'h00;

    // Reset state, then mid-cycle asynchronous assertion with data present
    #13;
    check("rst_hold_ready", 32'(o_us_ready), 32'd0);
    check_output("rst_hold", 1'b0, 0, 32'h0);
    @(negedge i_clk);
    i_async_rst_n = 1'b1;
    #1;
    check("rst_release_ready", 32'(o_us_ready), 32'd1);
    apply_stimulus(1'b1, 8'h40, 3'd0, 1'b0);
    apply_stimulus(1'b0, 8'h00, 3'd3, 1'b0);
    check_output("pre_rst", 1'b1, 3, 32'h40414200);
    i_async_rst_n = 1'b0;
    #1;
    check("async_rst_ready", 32'(o_us_ready), 32'd0);
    check("async_rst_valid", 32'(o_frag_valid), 32'd0);
    check("async_rst_size", 32'(o_frag_size), 32'd0);
    check("async_rst_frag", {o_frag[0], o_frag[1], o_frag[2], o_frag[3]}, 32'h0);
    @(negedge i_clk);
    i_frag_size   = 3'd0;
    i_async_rst_n = 1'b1;

    // Basic unpack with size-3 fragments
    apply_stimulus(1'b1, 8'h00, 3'd0, 1'b0);
    apply_stimulus(1'b0, 8'h00, 3'd3, 1'b1);
    check_output("basic_f0", 1'b1, 3, 32'h00010200);
    apply_stimulus(1'b0, 8'h00, 3'd3, 1'b1);
    check_output("basic_f1", 1'b1, 3, 32'h03040500);
    apply_stimulus(1'b0, 8'h00, 3'd3, 1'b1);
    check_output("basic_short", 1'b0, 3, 32'h0);
    apply_stimulus(1'b1, 8'h08, 3'd3, 1'b1);
    apply_stimulus(1'b0, 8'h00, 3'd3, 1'b1);
    check_output("basic_f2", 1'b1, 3, 32'h06070800);

    // Wrap-around of both write and read ranges
    do_reset();
    apply_stimulus(1'b1, 8'h00, 3'd0, 1'b0);
    apply_stimulus(1'b0, 8'h00, 3'd4, 1'b1);
    check_output("wrap_a", 1'b1, 4, 32'h00010203);
    apply_stimulus(1'b0, 8'h00, 3'd4, 1'b1);
    check_output("wrap_b", 1'b1, 4, 32'h04050607);
    apply_stimulus(1'b1, 8'd8, 3'd0, 1'b0);
    apply_stimulus(1'b1, 8'd16, 3'd0, 1'b0);
    apply_stimulus(1'b0, 8'h00, 3'd4, 1'b1);
    check_output("wrap_f0", 1'b1, 4, 32'h08090a0b);
    apply_stimulus(1'b0, 8'h00, 3'd4, 1'b1);
    check_output("wrap_f1", 1'b1, 4, 32'h0c0d0e0f);
    apply_stimulus(1'b0, 8'h00, 3'd4, 1'b1);
    check_output("wrap_f2", 1'b1, 4, 32'h10111213);
    apply_stimulus(1'b0, 8'h00, 3'd4, 1'b1);
    check_output("wrap_f3", 1'b1, 4, 32'h14151617);

    // Backpressure on both sides
    do_reset();
    apply_stimulus(1'b1, 8'h10, 3'd4, 1'b0);
    check_output("bp_empty", 1'b0, 4, 32'h0);
    apply_stimulus(1'b1, 8'h20, 3'd4, 1'b0);
    check_output("bp_hold0", 1'b1, 4, 32'h10111213);
    apply_stimulus(1'b1, 8'h30, 3'd4, 1'b0);
    check("bp_full_ready", 32'(o_us_ready), 32'd0);
    check_output("bp_hold1", 1'b1, 4, 32'h10111213);
    apply_stimulus(1'b1, 8'h30, 3'd4, 1'b1);
    check_output("bp_pop0", 1'b1, 4, 32'h10111213);
    apply_stimulus(1'b1, 8'h30, 3'd4, 1'b1);
    check("bp_cnt12_ready", 32'(o_us_ready), 32'd0);
    check_output("bp_pop1", 1'b1, 4, 32'h14151617);
    apply_stimulus(1'b1, 8'h30, 3'd4, 1'b0);
    check("bp_cnt8_ready", 32'(o_us_ready), 32'd1);
    check_output("bp_next", 1'b1, 4, 32'h20212223);

    // Clipping and zero-size requests
    do_reset();
    apply_stimulus(1'b1, 8'h50, 3'd0, 1'b1);
    apply_stimulus(1'b0, 8'h00, 3'd0, 1'b1);
    check_output("clip_zero", 1'b0, 0, 32'h0);
    apply_stimulus(1'b0, 8'h00, 3'd7, 1'b1);
    check_output("clip_seven", 1'b1, 4, 32'h50515253);
    apply_stimulus(1'b0, 8'h00, 3'd2, 1'b0);
    check_output("clip_two", 1'b1, 2, 32'h54550000);

    // Simultaneous push and pop
    do_reset();
    apply_stimulus(1'b1, 8'h60, 3'd0, 1'b0);
    apply_stimulus(1'b1, 8'h70, 3'd4, 1'b1);
    check("sim_ready", 32'(o_us_ready), 32'd1);
    check_output("sim_f0", 1'b1, 4, 32'h60616263);
    apply_stimulus(1'b0, 8'h00, 3'd4, 1'b1);
    check("sim_cnt12_ready", 32'(o_us_ready), 32'd0);
    check_output("sim_f1", 1'b1, 4, 32'h64656667);
    apply_stimulus(1'b0, 8'h00, 3'd4, 1'b1);
    check_output("sim_f2", 1'b1, 4, 32'h70717273);
    apply_stimulus(1'b0, 8'h00, 3'd4, 1'b1);
    check_output("sim_f3", 1'b1, 4, 32'h74757677);
    apply_stimulus(1'b0, 8'h00, 3'd4, 1'b1);
    check_output("sim_empty", 1'b0, 4, 32'h0);

    // Mixed traffic with odd sizes so fragments straddle the ring boundary
    do_reset();
    for (int k = 0; k < 60; k++)
      apply_stimulus(k % 3 != 2, 8'(k * 8), 3'(k % 6), k % 4 != 3);

    do_reset();
    @(negedge i_clk);
    #3;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
